// File: rtl/mp_addsub_mod.sv
// Multi-precision add/sub with modular add/sub modes. One limb per cycle,
// LS limb first, through one shared carry chain; modular modes always run a
// second full pass.
module mp_addsub_mod #(
    parameter int WIDTH = 513,
    parameter int LIMB  = 64
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_m,
    output logic [WIDTH:0]   result,
    output logic             busy,
    output logic             done
);

    localparam int NLIMB = (WIDTH + LIMB) / LIMB;
    localparam int EXT   = NLIMB * LIMB;
    localparam int CW    = $clog2(NLIMB + 1);
    localparam logic [CW-1:0] LAST = CW'(NLIMB - 1);

    typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [EXT-1:0]   r_a;
    logic [EXT-1:0]   r_b;
    logic [EXT-1:0]   r_m;
    logic [EXT-1:0]   r_r;
    logic [EXT-1:0]   r_t;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_neg;
    logic [1:0]       r_mode;
    logic [WIDTH:0]   r_result;

    logic             w_accept;
    logic             w_last;
    logic             w_pass1;
    logic             w_inv;
    logic [LIMB-1:0]  w_opa;
    logic [LIMB-1:0]  w_opb_raw;
    logic [LIMB-1:0]  w_opb;
    logic [LIMB:0]    w_sum;
    logic [EXT-1:0]   w_r_shift;
    logic [EXT-1:0]   w_r_rot;
    logic [EXT-1:0]   w_t_shift;
    logic             w_use_t;

    assign w_accept = start && (r_state == IDLE || r_state == DONE);
    assign w_last   = (r_cnt == LAST);
    assign w_pass1  = (r_state == PASS1);

    // PASS2 reuses the adder: modadd subtracts M (invert), modsub adds M.
    assign w_inv     = w_pass1 ? r_mode[0] : !r_mode[0];
    assign w_opa     = w_pass1 ? r_a[LIMB-1:0] : r_r[LIMB-1:0];
    assign w_opb_raw = w_pass1 ? r_b[LIMB-1:0] : r_m[LIMB-1:0];
    assign w_opb     = w_inv ? ~w_opb_raw : w_opb_raw;
    assign w_sum     = {1'b0, w_opa} + {1'b0, w_opb} + {{LIMB{1'b0}}, r_carry};

    assign w_r_shift = {w_sum[LIMB-1:0], r_r[EXT-1:LIMB]};
    assign w_r_rot   = {r_r[LIMB-1:0], r_r[EXT-1:LIMB]};
    assign w_t_shift = {w_sum[LIMB-1:0], r_t[EXT-1:LIMB]};
    assign w_use_t   = r_mode[0] ? r_neg : w_sum[LIMB];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = PASS1;
            PASS1:   if (w_last) w_state_nxt = r_mode[1] ? PASS2 : DONE;
            PASS2:   if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = start ? PASS1 : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_a      <= '0;
            r_b      <= '0;
            r_m      <= '0;
            r_r      <= '0;
            r_t      <= '0;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_neg    <= 1'b0;
            r_mode   <= 2'b00;
            r_result <= '0;
        end else if (w_accept) begin
            r_a     <= EXT'(in_a);
            r_b     <= EXT'(in_b);
            r_m     <= EXT'(in_m);
            r_r     <= '0;
            r_t     <= '0;
            r_cnt   <= '0;
            r_carry <= mode[0];
            r_neg   <= 1'b0;
            r_mode  <= mode;
        end else if (r_state == PASS1) begin
            r_a   <= r_a >> LIMB;
            r_b   <= r_b >> LIMB;
            r_r   <= w_r_shift;
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            if (w_last) begin
                // Carry-out of A + ~B + 1 is the inverse of the borrow.
                r_neg   <= !w_sum[LIMB];
                r_carry <= (r_mode == 2'b10);
                if (!r_mode[1]) r_result <= w_r_shift[WIDTH:0];
            end else begin
                r_carry <= w_sum[LIMB];
            end
        end else if (r_state == PASS2) begin
            r_m     <= r_m >> LIMB;
            r_r     <= w_r_rot;
            r_t     <= w_t_shift;
            r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
            r_carry <= w_sum[LIMB];
            if (w_last) r_result <= w_use_t ? w_t_shift[WIDTH:0] : w_r_rot[WIDTH:0];
        end
    end

    assign result = r_result;
    assign busy   = (r_state == PASS1) || (r_state == PASS2);
    assign done   = (r_state == DONE);

endmodule

// File: tb/tb_mp_addsub_mod.sv
// Directed bench for mp_addsub_mod: default 513/64 instance plus a 32/8 instance.
module tb_mp_addsub_mod;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         resetn;
    logic         start0;
    logic [1:0]   mode0;
    logic [512:0] a0, b0, m0;
    logic [513:0] res0;
    logic         busy0, done0;

    logic         start1;
    logic [1:0]   mode1;
    logic [31:0]  a1, b1, m1;
    logic [32:0]  res1;
    logic         busy1, done1;

    int n_checks = 0;
    int n_errors = 0;

    mp_addsub_mod #(.WIDTH(513), .LIMB(64)) u_dut0 (
        .clk(clk), .resetn(resetn), .start(start0), .mode(mode0),
        .in_a(a0), .in_b(b0), .in_m(m0),
        .result(res0), .busy(busy0), .done(done0)
    );

    mp_addsub_mod #(.WIDTH(32), .LIMB(8)) u_dut1 (
        .clk(clk), .resetn(resetn), .start(start1), .mode(mode1),
        .in_a(a1), .in_b(b1), .in_m(m1),
        .result(res1), .busy(busy1), .done(done1)
    );

    task automatic check(input string tag, input logic [513:0] got, input logic [513:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic go0(input logic [1:0] md, input logic [512:0] a, input logic [512:0] b,
                       input logic [512:0] m);
        mode0  = md;
        a0     = a;
        b0     = b;
        m0     = m;
        start0 = 1'b1;
    endtask

    // Called at the cycle-0 negedge; returns at the negedge of the done cycle.
    task automatic wait0(input string tag, input logic [513:0] exp, input int lat,
                         input bit chg, input bit poke);
        int dcyc = -1;
        int nb   = 0;
        for (int cyc = 1; cyc <= lat + 5; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start0 = 1'b0;
            if (chg && cyc == 2) a0 = {513{1'b1}};
            if (poke && cyc == 3) start0 = 1'b1;
            if (poke && cyc == 5) start0 = 1'b0;
            if (busy0) nb++;
            if (done0) begin
                dcyc = cyc;
                break;
            end
        end
        check({tag, "_lat"}, 514'(dcyc), 514'(lat));
        check({tag, "_busy"}, 514'(nb), 514'(lat - 1));
        check({tag, "_res"}, res0, exp);
    endtask

    task automatic run0(input string tag, input logic [1:0] md, input logic [512:0] a,
                        input logic [512:0] b, input logic [512:0] m,
                        input logic [513:0] exp, input int lat);
        go0(md, a, b, m);
        wait0(tag, exp, lat, 1'b0, 1'b0);
        @(negedge clk);
        check({tag, "_pulse"}, 514'(done0), 514'd0);
    endtask

    initial begin
        int nd;
        int dcyc;
        int nb;
        resetn = 1'b0;
        start0 = 1'b0; mode0 = 2'b00; a0 = '0; b0 = '0; m0 = '0;
        start1 = 1'b0; mode1 = 2'b00; a1 = '0; b1 = '0; m1 = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_res0", res0, 514'd0);
        check("rst_busy0", 514'(busy0), 514'd0);
        check("rst_done0", 514'(done0), 514'd0);
        check("rst_res1", 514'(res1), 514'd0);
        check("rst_busy1", 514'(busy1), 514'd0);
        resetn = 1'b1;
        @(negedge clk);

        run0("add1", 2'b00, 513'd1, 513'd1, 513'd0, 514'd2, 10);
        run0("sub1", 2'b01, 513'd1, 513'd1, 513'd0, 514'd0, 10);
        run0("sub01", 2'b01, 513'd0, 513'd1, 513'd0, {514{1'b1}}, 10);
        run0("addmax", 2'b00, {513{1'b1}}, {513{1'b1}}, 513'd0, {{513{1'b1}}, 1'b0}, 10);
        run0("madd79", 2'b10, 513'd7, 513'd9, 513'd13, 514'd3, 19);
        run0("madd23", 2'b10, 513'd2, 513'd3, 513'd13, 514'd5, 19);
        run0("msub39", 2'b11, 513'd3, 513'd9, 513'd13, 514'd7, 19);
        run0("msub93", 2'b11, 513'd9, 513'd3, 513'd13, 514'd6, 19);
        run0("msub55", 2'b11, 513'd5, 513'd5, 513'd13, 514'd0, 19);

        go0(2'b00, 513'd5, 513'd6, 513'd0);
        wait0("b2b1", 514'd11, 10, 1'b0, 1'b0);
        go0(2'b01, 513'd100, 513'd58, 513'd0);
        wait0("b2b2", 514'd42, 10, 1'b0, 1'b0);
        @(negedge clk);

        go0(2'b00, 513'd20, 513'd22, 513'd0);
        wait0("poke", 514'd42, 10, 1'b0, 1'b1);
        @(negedge clk);

        go0(2'b00, 513'd3, 513'd4, 513'd0);
        wait0("chg", 514'd7, 10, 1'b1, 1'b0);
        @(negedge clk);

        go0(2'b10, 513'd2, 513'd3, 513'd13);
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start0 = 1'b0;
        end
        resetn = 1'b0;
        #1;
        check("mid_rst_busy", 514'(busy0), 514'd0);
        check("mid_rst_done", 514'(done0), 514'd0);
        check("mid_rst_res", res0, 514'd0);
        @(negedge clk);
        resetn = 1'b1;
        nd = 0;
        for (int cyc = 0; cyc < 25; cyc++) begin
            @(negedge clk);
            if (done0) nd++;
        end
        check("mid_rst_nodone", 514'(nd), 514'd0);

        mode1 = 2'b10; a1 = 32'hFFFF_FFFA; b1 = 32'hFFFF_FFFA; m1 = 32'hFFFF_FFFB;
        start1 = 1'b1;
        dcyc = -1;
        nb = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start1 = 1'b0;
            if (busy1) nb++;
            if (done1) begin
                dcyc = cyc;
                break;
            end
        end
        check("small_lat", 514'(dcyc), 514'd11);
        check("small_busy", 514'(nb), 514'd10);
        check("small_res", 514'(res1), 514'h0_FFFF_FFF9);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
